symbol_freq_counter: RTL and testbench

Downstream consumer of the symbol memory init unit in the Huffman Sort path. On start, it reads every stored symbol through the memory's synchronous read port. It tallies occurrences of each distinct symbol in a small associative table. It then streams (symbol, count) pairs, in first-appearance order, to the sorter over a valid/ready handshake.

---
 rtl/huffman_pkg.sv | 19 +
 rtl/symbol_freq_counter_freq_table.sv | 80 ++++++++
 rtl/symbol_freq_counter.sv | 114 +++++++++++
 tb/tb_symbol_freq_counter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman sort path: FSM state encoding and the
// (symbol, count) pair record handed from the frequency counter to the sorter.
package huffman_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_EMIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int PAIR_DATA_WIDTH  = 16;
    localparam int PAIR_COUNT_WIDTH = 5;

    typedef struct packed {
        logic [PAIR_DATA_WIDTH-1:0]  symbol;
        logic [PAIR_COUNT_WIDTH-1:0] count;
    } freq_pair_t;

endpackage

// File: rtl/symbol_freq_counter_freq_table.sv
// CAM-style frequency table: parallel match against all valid entries, then
// either a saturating increment, an allocation at the next free slot, or a drop.
module freq_table #(
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_WIDTH = 5,
    parameter int MAX_UNIQUE  = 16,
    parameter int IDX_WIDTH   = 5,
    parameter int SLOT_W      = (MAX_UNIQUE > 1) ? $clog2(MAX_UNIQUE) : 1
) (
    input  logic                   rClk,
    input  logic                   rRst_n,
    input  logic                   clear,
    input  logic                   tally_en,
    input  logic [DATA_WIDTH-1:0]  tally_symbol,
    input  logic [SLOT_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0]  rd_symbol,
    output logic [COUNT_WIDTH-1:0] rd_count,
    output logic [IDX_WIDTH-1:0]   unique_count,
    output logic                   overflow
);

    logic [MAX_UNIQUE-1:0]  valid;
    logic [DATA_WIDTH-1:0]  symbols [MAX_UNIQUE];
    logic [COUNT_WIDTH-1:0] counts  [MAX_UNIQUE];

    logic              hit;
    logic [SLOT_W-1:0] hit_idx;
    logic              full;
    logic [SLOT_W-1:0] alloc_idx;
    logic              do_inc;
    logic              do_alloc;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < MAX_UNIQUE; i++) begin
            if (valid[i] && (symbols[i] == tally_symbol)) begin
                hit     = 1'b1;
                hit_idx = SLOT_W'(i);
            end
        end
    end

    assign full      = (unique_count == IDX_WIDTH'(MAX_UNIQUE));
    assign alloc_idx = unique_count[SLOT_W-1:0];
    assign do_inc    = tally_en && hit && (counts[hit_idx] != '1);
    assign do_alloc  = tally_en && !hit && !full;

    always_ff @(posedge rClk) begin
        if (!rRst_n || clear) begin
            valid        <= '0;
            unique_count <= '0;
            overflow     <= 1'b0;
        end else if (tally_en && !hit) begin
            if (full) begin
                overflow <= 1'b1;
            end else begin
                valid[alloc_idx] <= 1'b1;
                unique_count     <= unique_count + 1'b1;
            end
        end
    end

    // Payload storage is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge rClk) begin
        if (rRst_n && !clear) begin
            if (do_inc) begin
                counts[hit_idx] <= counts[hit_idx] + 1'b1;
            end
            if (do_alloc) begin
                symbols[alloc_idx] <= tally_symbol;
                counts[alloc_idx]  <= COUNT_WIDTH'(1);
            end
        end
    end

    assign rd_symbol = symbols[rd_idx];
    assign rd_count  = counts[rd_idx];

endmodule

// File: rtl/symbol_freq_counter.sv
// Scans the symbol memory, tallies distinct symbols in freq_table, then streams
// (symbol, count) pairs in first-appearance order over a valid/ready handshake.
module symbol_freq_counter
    import huffman_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int TOTAL_SYMBOLS = 10,
    parameter int ADDR_WIDTH    = 4,
    parameter int MAX_UNIQUE    = 16,
    parameter int COUNT_WIDTH   = 5,
    parameter int IDX_WIDTH     = 5
) (
    input  logic                   rClk,
    input  logic                   rRst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [IDX_WIDTH-1:0]   unique_count,
    output logic                   mem_rEn,
    output logic [ADDR_WIDTH-1:0]  mem_rAddr,
    input  logic [DATA_WIDTH-1:0]  mem_rData,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_symbol,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   out_last
);

    localparam int SLOT_W = (MAX_UNIQUE > 1) ? $clog2(MAX_UNIQUE) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_SYMBOLS - 1);

    logic [2:0]             state;
    logic [ADDR_WIDTH-1:0]  addr;
    logic                   rd_pend;
    logic [IDX_WIDTH-1:0]   emit_idx;
    logic                   start_accept;
    logic                   is_last;
    logic [DATA_WIDTH-1:0]  tbl_symbol;
    logic [COUNT_WIDTH-1:0] tbl_count;

    assign start_accept = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign is_last      = (emit_idx == unique_count - 1'b1);

    // rd_pend marks that mem_rData carries a word requested in the previous cycle.
    always_ff @(posedge rClk) begin
        if (!rRst_n) begin
            state    <= ST_IDLE;
            addr     <= '0;
            rd_pend  <= 1'b0;
            emit_idx <= '0;
        end else begin
            rd_pend <= (state == ST_READ);
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_READ;
                        addr     <= '0;
                        emit_idx <= '0;
                    end
                end
                ST_READ: begin
                    addr <= addr + 1'b1;
                    if (addr == LAST_ADDR) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state    <= ST_EMIT;
                    emit_idx <= '0;
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (is_last) begin
                            state <= ST_DONE;
                        end else begin
                            emit_idx <= emit_idx + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    freq_table #(
        .DATA_WIDTH  (DATA_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH),
        .MAX_UNIQUE  (MAX_UNIQUE),
        .IDX_WIDTH   (IDX_WIDTH),
        .SLOT_W      (SLOT_W)
    ) u_table (
        .rClk         (rClk),
        .rRst_n       (rRst_n),
        .clear        (start_accept),
        .tally_en     (rd_pend),
        .tally_symbol (mem_rData),
        .rd_idx       (emit_idx[SLOT_W-1:0]),
        .rd_symbol    (tbl_symbol),
        .rd_count     (tbl_count),
        .unique_count (unique_count),
        .overflow     (overflow)
    );

    assign busy       = (state == ST_READ) || (state == ST_DRAIN) || (state == ST_EMIT);
    assign done       = (state == ST_DONE);
    assign mem_rEn    = (state == ST_READ);
    assign mem_rAddr  = mem_rEn ? addr : '0;
    assign out_valid  = (state == ST_EMIT);
    assign out_symbol = out_valid ? tbl_symbol : '0;
    assign out_count  = out_valid ? tbl_count : '0;
    assign out_last   = out_valid && is_last;

endmodule

// File: tb/tb_symbol_freq_counter.sv
// Directed bench for symbol_freq_counter: a default instance plus a
// MAX_UNIQUE=4 instance sharing the same memory image and control inputs.
module tb_symbol_freq_counter;
    import huffman_pkg::*;

    logic        rClk = 1'b0;
    logic        rRst_n;
    logic        start;
    logic        out_ready;

    logic        busy, done, overflow, mem_rEn, out_valid, out_last;
    logic [4:0]  unique_count;
    logic [3:0]  mem_rAddr;
    logic [15:0] mem_rData, out_symbol;
    logic [4:0]  out_count;

    logic        busy_s, done_s, overflow_s, mem_rEn_s, out_valid_s, out_last_s;
    logic [2:0]  unique_count_s;
    logic [3:0]  mem_rAddr_s;
    logic [15:0] mem_rData_s, out_symbol_s;
    logic [4:0]  out_count_s;

    logic [15:0] mem [16];

    int checks = 0;
    int failures = 0;

    logic [15:0] got_sym [16];
    logic [4:0]  got_cnt [16];
    logic        got_last [16];

    always #5 rClk = ~rClk;

    symbol_freq_counter dut (
        .rClk(rClk), .rRst_n(rRst_n), .start(start), .busy(busy), .done(done),
        .overflow(overflow), .unique_count(unique_count), .mem_rEn(mem_rEn),
        .mem_rAddr(mem_rAddr), .mem_rData(mem_rData), .out_valid(out_valid),
        .out_ready(out_ready), .out_symbol(out_symbol), .out_count(out_count),
        .out_last(out_last)
    );

    symbol_freq_counter #(.MAX_UNIQUE(4), .IDX_WIDTH(3)) dut_small (
        .rClk(rClk), .rRst_n(rRst_n), .start(start), .busy(busy_s), .done(done_s),
        .overflow(overflow_s), .unique_count(unique_count_s), .mem_rEn(mem_rEn_s),
        .mem_rAddr(mem_rAddr_s), .mem_rData(mem_rData_s), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_symbol(out_symbol_s), .out_count(out_count_s),
        .out_last(out_last_s)
    );

    // Synchronous-read memory model, one data register per instance.
    always @(posedge rClk) begin
        if (mem_rEn)   mem_rData   <= mem[mem_rAddr];
        if (mem_rEn_s) mem_rData_s <= mem[mem_rAddr_s];
    end

    task automatic step();
        @(posedge rClk);
        #1;
    endtask

    task automatic load_pattern_a();
        logic [15:0] pat [10];
        pat = '{16'h0041, 16'h0042, 16'h0041, 16'h0043, 16'h0041,
                16'h0042, 16'h0044, 16'h0041, 16'h0045, 16'h0042};
        for (int i = 0; i < 16; i++) mem[i] = (i < 10) ? pat[i] : 16'hDEAD;
    endtask

    // Runs (optionally starting) a scan, recording every transferred pair until done.
    task automatic collect(input bit do_start, input int sel, input bit stall_mode,
                           output int n, output int first_lat, output int done_delay,
                           output bit timeout, output bit stable_ok);
        int cyc, last_xfer, e;
        bit v, l, dn, prev_stall, pl;
        logic [15:0] s, ps;
        logic [4:0] c, pc;
        n = 0; first_lat = -1; done_delay = -1; timeout = 1'b1; stable_ok = 1'b1;
        prev_stall = 1'b0; last_xfer = 0; e = 0; ps = '0; pc = '0; pl = 1'b0;
        if (do_start) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
        cyc = 1;
        while (cyc < 200) begin
            v  = sel ? out_valid_s  : out_valid;
            s  = sel ? out_symbol_s : out_symbol;
            c  = sel ? out_count_s  : out_count;
            l  = sel ? out_last_s   : out_last;
            dn = sel ? done_s       : done;
            if (stall_mode && v) begin
                out_ready = (e % 3 == 0);
                e++;
            end else begin
                out_ready = 1'b1;
            end
            if (v && first_lat < 0) first_lat = cyc;
            if (prev_stall && (!v || s !== ps || c !== pc || l !== pl)) stable_ok = 1'b0;
            if (dn) begin
                done_delay = cyc - last_xfer;
                timeout = 1'b0;
                break;
            end
            if (v && out_ready && n < 16) begin
                got_sym[n] = s; got_cnt[n] = c; got_last[n] = l;
                n++;
                last_xfer = cyc;
            end
            prev_stall = v && !out_ready;
            ps = s; pc = c; pl = l;
            step();
            cyc++;
        end
        out_ready = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_reset();
        rRst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
        step(); step();
        checks++;
        if ({busy, done, overflow, mem_rEn, out_valid, out_last} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b want 000000",
                     {busy, done, overflow, mem_rEn, out_valid, out_last});
        end
        checks++;
        if (unique_count !== 5'd0 || mem_rAddr !== 4'd0) begin
            failures++;
            $display("[TB] FAIL reset_counts: uc=%0d addr=%0d want 0,0", unique_count, mem_rAddr);
        end
        checks++;
        if (out_symbol !== 16'h0 || out_count !== 5'd0) begin
            failures++;
            $display("[TB] FAIL reset_data: sym=%h cnt=%0d want 0,0", out_symbol, out_count);
        end
        rRst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        freq_pair_t exp [5];
        int n, lat, dd;
        bit to, st;
        exp = '{'{16'h0041, 5'd4}, '{16'h0042, 5'd3}, '{16'h0043, 5'd1},
                '{16'h0044, 5'd1}, '{16'h0045, 5'd1}};
        load_pattern_a();
        collect(1'b1, 0, 1'b0, n, lat, dd, to, st);
        checks++;
        if (to || n != 5) begin
            failures++;
            $display("[TB] FAIL basic_pairs: timeout=%0d n=%0d want 0,5", to, n);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_sym[i] !== exp[i].symbol || got_cnt[i] !== exp[i].count || got_last[i] !== (i == 4)) begin
                failures++;
                $display("[TB] FAIL basic_pair%0d: got (%h,%0d,last=%b) want (%h,%0d,last=%b)",
                         i, got_sym[i], got_cnt[i], got_last[i], exp[i].symbol, exp[i].count, i == 4);
            end
        end
        checks++;
        if (lat != 12) begin
            failures++;
            $display("[TB] FAIL basic_latency: got %0d want 12", lat);
        end
        checks++;
        if (dd != 1) begin
            failures++;
            $display("[TB] FAIL basic_done_delay: got %0d want 1", dd);
        end
        checks++;
        if (unique_count !== 5'd5 || overflow !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_status: uc=%0d ovf=%b done=%b want 5,0,1", unique_count, overflow, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_sym [5];
        logic [4:0]  exp_cnt [5];
        int n, lat, dd;
        bit to, st;
        exp_sym = '{16'h0041, 16'h0042, 16'h0043, 16'h0044, 16'h0045};
        exp_cnt = '{5'd4, 5'd3, 5'd1, 5'd1, 5'd1};
        collect(1'b1, 0, 1'b1, n, lat, dd, to, st);
        checks++;
        if (to || n != 5) begin
            failures++;
            $display("[TB] FAIL stall_pairs: timeout=%0d n=%0d want 0,5", to, n);
        end
        checks++;
        if (!st) begin
            failures++;
            $display("[TB] FAIL stall_stable: outputs changed during stall, got 0 want 1");
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_sym[i] !== exp_sym[i] || got_cnt[i] !== exp_cnt[i]) begin
                failures++;
                $display("[TB] FAIL stall_pair%0d: got (%h,%0d) want (%h,%0d)",
                         i, got_sym[i], got_cnt[i], exp_sym[i], exp_cnt[i]);
            end
        end
    endtask

    task automatic test_single_symbol();
        int n, lat, dd;
        bit to, st;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0007;
        collect(1'b1, 0, 1'b0, n, lat, dd, to, st);
        checks++;
        if (to || n != 1 || got_sym[0] !== 16'h0007 || got_cnt[0] !== 5'd10 || got_last[0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_pair: n=%0d got (%h,%0d,last=%b) want 1 (0007,10,last=1)",
                     n, got_sym[0], got_cnt[0], got_last[0]);
        end
        checks++;
        if (unique_count !== 5'd1) begin
            failures++;
            $display("[TB] FAIL single_uc: got %0d want 1", unique_count);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_sym [4];
        logic [4:0]  exp_cnt [4];
        int n, lat, dd;
        bit to, st;
        exp_sym = '{16'h0041, 16'h0042, 16'h0043, 16'h0044};
        exp_cnt = '{5'd4, 5'd3, 5'd1, 5'd1};
        load_pattern_a();
        collect(1'b1, 1, 1'b0, n, lat, dd, to, st);
        checks++;
        if (to || n != 4) begin
            failures++;
            $display("[TB] FAIL ovf_pairs: timeout=%0d n=%0d want 0,4", to, n);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_sym[i] !== exp_sym[i] || got_cnt[i] !== exp_cnt[i] || got_last[i] !== (i == 3)) begin
                failures++;
                $display("[TB] FAIL ovf_pair%0d: got (%h,%0d,last=%b) want (%h,%0d,last=%b)",
                         i, got_sym[i], got_cnt[i], got_last[i], exp_sym[i], exp_cnt[i], i == 3);
            end
        end
        checks++;
        if (overflow_s !== 1'b1 || unique_count_s !== 3'd4) begin
            failures++;
            $display("[TB] FAIL ovf_status: ovf=%b uc=%0d want 1,4", overflow_s, unique_count_s);
        end
    endtask

    task automatic test_reset_mid_run();
        int k, n, lat, dd;
        bit to, st;
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (mem_rAddr !== 4'd5 && k < 20) begin
            step();
            k++;
        end
        checks++;
        if (mem_rAddr !== 4'd5 || mem_rEn !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midrst_reach: addr=%0d en=%b want 5,1", mem_rAddr, mem_rEn);
        end
        rRst_n = 1'b0;
        step();
        rRst_n = 1'b1;
        checks++;
        if ({busy, done, overflow, mem_rEn, out_valid, out_last} !== 6'b0 ||
            unique_count !== 5'd0 || mem_rAddr !== 4'd0 || out_symbol !== 16'h0 || out_count !== 5'd0) begin
            failures++;
            $display("[TB] FAIL midrst_zero: flags=%b uc=%0d addr=%0d sym=%h cnt=%0d want all 0",
                     {busy, done, overflow, mem_rEn, out_valid, out_last}, unique_count, mem_rAddr,
                     out_symbol, out_count);
        end
        step();
        collect(1'b1, 0, 1'b0, n, lat, dd, to, st);
        checks++;
        if (to || n != 5 || got_sym[0] !== 16'h0041 || got_cnt[0] !== 5'd4 ||
            got_sym[4] !== 16'h0045 || got_cnt[4] !== 5'd1 || lat != 12) begin
            failures++;
            $display("[TB] FAIL midrst_rerun: n=%0d lat=%0d p0=(%h,%0d) p4=(%h,%0d) want 5,12,(0041,4),(0045,1)",
                     n, lat, got_sym[0], got_cnt[0], got_sym[4], got_cnt[4]);
        end
    endtask

    task automatic test_start_during_emit();
        int k, xfers;
        logic [15:0] first_sym;
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (!out_valid && k < 40) begin
            step();
            k++;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || out_symbol !== 16'h0041 || out_count !== 5'd4) begin
            failures++;
            $display("[TB] FAIL emit_start_ignored: valid=%b busy=%b pair=(%h,%0d) want 1,1,(0041,4)",
                     out_valid, busy, out_symbol, out_count);
        end
        out_ready = 1'b1;
        xfers = 0; k = 0; first_sym = '0;
        while (!done && k < 40) begin
            if (out_valid) begin
                if (xfers == 0) first_sym = out_symbol;
                xfers++;
            end
            step();
            k++;
        end
        checks++;
        if (!done || xfers != 5 || first_sym !== 16'h0041) begin
            failures++;
            $display("[TB] FAIL emit_start_run: done=%b xfers=%0d first=%h want 1,5,0041", done, xfers, first_sym);
        end
    endtask

    task automatic test_restart_after_done();
        int n, lat, dd;
        bit to, st;
        // dut_small still holds overflow from its earlier run with the same data
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || unique_count !== 5'd0 || overflow_s !== 1'b0 || unique_count_s !== 3'd0) begin
            failures++;
            $display("[TB] FAIL restart_clear: done=%b busy=%b uc=%0d ovf_s=%b uc_s=%0d want 0,1,0,0,0",
                     done, busy, unique_count, overflow_s, unique_count_s);
        end
        collect(1'b0, 0, 1'b0, n, lat, dd, to, st);
        checks++;
        if (to || n != 5 || got_sym[1] !== 16'h0042 || got_cnt[1] !== 5'd3 || got_last[4] !== 1'b1 || lat != 12) begin
            failures++;
            $display("[TB] FAIL restart_rerun: n=%0d lat=%0d p1=(%h,%0d) last4=%b want 5,12,(0042,3),1",
                     n, lat, got_sym[1], got_cnt[1], got_last[4]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_single_symbol();
        test_overflow();
        test_reset_mid_run();
        test_start_during_emit();
        test_restart_after_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
